aes_block_loader: RTL
=====================

// Module: aes_block_loader
// PURPOSE
//  Upstream feeder for the combinational AES-256 encryption core. Accepts key/plaintext as a
//  32-bit word stream (valid/ready). Assembles the 256-bit key and 128-bit plaintext into
//  registers that drive the core, and holds them stable for a programmable settle window
//  (multicycle path through the core). Then captures the core's ciphertext and offers it
//  downstream with valid/ready.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles pt_o/key_o held stable before ct_i is sampled; legal range 1..255
// PORTS
//  clk_i      in   1    single clock; all state updates on rising edge
//  reset_i    in   1    synchronous, active-high reset
//  data_i     in   32   stream word; first word of each field is most significant
//  v_i        in   1    data_i valid
//  ready_o    out  1    loader can accept a word this cycle
//  key_o      out  256  registered key to core initial_key
//  pt_o       out  128  registered plaintext to core plaintext
//  ct_i       in   128  ciphertext from core
//  ct_o       out  128  captured ciphertext
//  v_o        out  1    ct_o valid
//  ready_i    in   1    downstream accepts ct_o
//  reuse_key_i in  1    present only with AES_LOADER_KEY_CACHE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=S_KEY; word_cnt=0; settle_cnt=0; key_o=0; pt_o=0; ct_o=0; v_o=0.
//    ready_o=1 the first cycle after reset. Reset mid-job discards all partial data.
//  - A word transfer occurs on a cycle with v_i && ready_o. ready_o=1 only in S_KEY and S_PT.
//  - S_KEY: each transfer shifts data_i into key_o, entering at the LSB end (key_o <= {key_o[223:0],data_i}).
//    The 8th transfer (word_cnt==7) -> S_PT, word_cnt=0.
//  - S_PT: same shifting into pt_o. The 4th transfer -> S_WAIT, settle_cnt=0.
//  - S_WAIT: settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1: ct_o<=ct_i, v_o<=1, -> S_OUT.
//    Core-to-capture latency = exactly SETTLE_CYCLES cycles after the last pt word transfer.
//  - S_OUT: v_o held with ct_o stable until v_o && ready_i. On that cycle v_o<=0 and the next state is
//    S_KEY (or S_PT, see CONFIGURATION). Next input is accepted on the following cycle (no overlap).
//  - key_o/pt_o change only on word transfers; stable throughout S_WAIT and S_OUT.
//  - v_i while ready_o=0 is ignored (stalls upstream). ready_i outside S_OUT is ignored.
//  - Counters: word_cnt 3 bits, wraps to 0 on field completion; settle_cnt 8 bits, never wraps in range.
// CONFIGURATION
//  AES_LOADER_KEY_CACHE_EN defined:
//   - Port reuse_key_i exists; internal key_valid_q is set on the 8th key word and cleared by reset.
//   - reuse_key_i is sampled on the S_OUT handshake cycle: if 1 and key_valid_q, the next state is S_PT
//     and key_o is retained. Otherwise the next state is S_KEY.
//  AES_LOADER_KEY_CACHE_EN undefined:
//   - No reuse_key_i port; every job loads 8 key words then 4 pt words.
// STRUCTURE
//  - aes_pkg: state enum {S_KEY,S_PT,S_WAIT,S_OUT}; KEY_WORDS=8, PT_WORDS=4, WORD_W=32.
//  - Sub-module aes_shift_in_reg #(WORDS): word-wide shift-in register with load enable.
//    Instantiated twice (key, pt). FSM and counters stay in the top.
//  - Core is instantiated beside this block in the bench/top, not inside it.
// TESTING (bench wires key_o/pt_o/ct_i to the AES-256 core)
//  1 FIPS-197 C.3: key words 00010203..1c1d1e1f, pt words 00112233..ccddeeff, ready_i=1
//    -> v_o rises SETTLE_CYCLES cycles after the 12th transfer;
//       ct_o=8ea2b7ca516745bfeafc49904b496089.
//  2 Backpressure: ready_i=0 for 10 cycles in S_OUT -> v_o and ct_o stable, ready_o=0 throughout;
//    ready_i=1 -> v_o drops the next cycle, ready_o=1.
//  3 Bubbly input: v_i toggles randomly across 12 words -> same ct as test 1; no word lost or duplicated.
//  4 Reset mid-load after 5 key words, then a full C.3 job -> correct ct; outputs zero right after reset.
//  5 Back-to-back: two jobs (C.3, then all-zero key/pt) -> second ct=dc95c078a2408989ad48a21492842087.
//  6 KEY_CACHE_EN: job 1 C.3; reuse_key_i=1 at handshake; job 2 sends only 4 pt words (C.3 pt) -> same ct;
//    reuse_key_i=1 right after reset -> FSM still requires key words.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and widths for the AES block loader and its shift-in registers.
package aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned KEY_WORDS = 8;
    localparam int unsigned PT_WORDS  = 4;
    localparam int unsigned KEY_W     = WORD_W * KEY_WORDS;
    localparam int unsigned PT_W      = WORD_W * PT_WORDS;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned SETTLE_W  = 8;

    typedef enum logic [1:0] {
        S_KEY  = 2'd0,
        S_PT   = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/aes_shift_in_reg.sv
// Word-wide shift-in register: each load pushes data_i in at the LSB end,
// so the first word loaded ends up most significant.
module aes_shift_in_reg
    import aes_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [WORD_W-1:0]       data_i,
    output logic [WORDS*WORD_W-1:0] q_o
);

    localparam int unsigned W = WORDS * WORD_W;

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= {data_q[W-WORD_W-1:0], data_i};
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/aes_block_loader.sv
// Streams key/plaintext words into registers feeding a combinational AES-256 core, holds them for
// SETTLE_CYCLES, then captures the ciphertext. Optional key reuse: AES_LOADER_KEY_CACHE_EN.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              v_i,
    output logic              ready_o,
    output logic [KEY_W-1:0]  key_o,
    output logic [PT_W-1:0]   pt_o,
    input  logic [PT_W-1:0]   ct_i,
    output logic [PT_W-1:0]   ct_o,
    output logic              v_o,
`ifdef AES_LOADER_KEY_CACHE_EN
    input  logic              reuse_key_i,
`endif
    input  logic              ready_i
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [PT_W-1:0]     ct_q, ct_d;
    logic                v_q, v_d;
    logic                ready_q, ready_d;
    logic                key_ld, pt_ld;
    logic                xfer;
    logic                reuse_ok;

    assign xfer = v_i && ready_q;

    aes_shift_in_reg #(.WORDS(KEY_WORDS)) u_key_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (key_ld),
        .data_i  (data_i),
        .q_o     (key_o)
    );

    aes_shift_in_reg #(.WORDS(PT_WORDS)) u_pt_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (pt_ld),
        .data_i  (data_i),
        .q_o     (pt_o)
    );

`ifdef AES_LOADER_KEY_CACHE_EN
    // A complete key stays usable until reset; partial keys never count.
    logic key_valid_q, key_valid_d;

    assign key_valid_d = key_valid_q
                       | (key_ld && (word_cnt_q == CNT_W'(KEY_WORDS - 1)));
    assign reuse_ok    = reuse_key_i && key_valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
        end
    end
`else
    assign reuse_ok = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_KEY;
            word_cnt_q   <= '0;
            settle_cnt_q <= '0;
            ct_q         <= '0;
            v_q          <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            ct_q         <= ct_d;
            v_q          <= v_d;
            ready_q      <= ready_d;
        end
    end

    // Next state; ready is registered from the state being entered.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        settle_cnt_d = settle_cnt_q;
        ct_d         = ct_q;
        v_d          = v_q;
        key_ld       = 1'b0;
        pt_ld        = 1'b0;

        unique case (state_q)
            S_KEY: begin
                if (xfer) begin
                    key_ld = 1'b1;
                    if (word_cnt_q == CNT_W'(KEY_WORDS - 1)) begin
                        word_cnt_d = '0;
                        state_d    = S_PT;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PT: begin
                if (xfer) begin
                    pt_ld = 1'b1;
                    if (word_cnt_q == CNT_W'(PT_WORDS - 1)) begin
                        word_cnt_d   = '0;
                        settle_cnt_d = '0;
                        state_d      = S_WAIT;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // Core inputs have been stable SETTLE_CYCLES cycles when this fires.
                settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    ct_d    = ct_i;
                    v_d     = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (v_q && ready_i) begin
                    v_d     = 1'b0;
                    state_d = reuse_ok ? S_PT : S_KEY;
                end
            end
            default: begin
                state_d = S_KEY;
            end
        endcase

        ready_d = (state_d == S_KEY) || (state_d == S_PT);
    end

    assign ready_o = ready_q;
    assign ct_o    = ct_q;
    assign v_o     = v_q;

endmodule
